mem_arbiter: RTL and testbench

- Shares the single memory-controller port (addr/data/width/read/write/ok) between two requesters: the CPU and the DMA engine.
- Fixed priority DMA > CPU, with a starvation guard that forces a CPU slot after a bounded run of DMA grants.
- Sits between the CPU/DMA blocks and the memory controller. The top level maps m_wdata/m_rdata onto the bidirectional mem_data bus.

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-controller port between the CPU and the DMA
// engine. DMA has fixed priority over the CPU; a run counter forces one CPU
// slot after DMA_RUN_MAX consecutive DMA grants while the CPU is waiting.
module mem_arbiter #(
    parameter int unsigned DMA_RUN_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_width,
    input  logic        cpu_we,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_width,
    input  logic        dma_we,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_width,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_rdata,
    input  logic        m_ok,
    output logic [1:0]  grant
);

    localparam int unsigned RUN_W = 8;
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(DMA_RUN_MAX);
    localparam logic [RUN_W-1:0] RUN_SAT   = {RUN_W{1'b1}};

    // Encoding doubles as the grant value
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CPU  = 2'b01,
        DMA  = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [RUN_W-1:0] run_cnt, run_cnt_nxt;

    // Read data is a straight pass-through; only meaningful in the ack cycle
    assign cpu_rdata = m_rdata;
    assign dma_rdata = m_rdata;

    // State and run counter registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_cnt_nxt;
        end
    end

    // Arbitration, bus muxing, completion and run-counter update
    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        m_addr      = '0;
        m_wdata     = '0;
        m_width     = '0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        cpu_ack     = 1'b0;
        dma_ack     = 1'b0;
        grant       = state;

        case (state)
            IDLE: begin
                if (!cpu_req) begin
                    run_cnt_nxt = '0;
                end
                if (dma_req && cpu_req && (run_cnt >= RUN_LIMIT)) begin
                    state_nxt = CPU;
                end else if (dma_req) begin
                    state_nxt = DMA;
                end else if (cpu_req) begin
                    state_nxt = CPU;
                end
            end

            CPU: begin
                m_addr  = cpu_addr;
                m_wdata = cpu_wdata;
                m_width = cpu_width;
                m_read  = cpu_req & ~cpu_we;
                m_write = cpu_req & cpu_we;
                cpu_ack = cpu_req & m_ok;
                // Dropped request aborts; completion returns to arbitration
                if (!cpu_req) begin
                    state_nxt = IDLE;
                end else if (m_ok) begin
                    state_nxt   = IDLE;
                    run_cnt_nxt = '0;
                end
            end

            DMA: begin
                m_addr  = dma_addr;
                m_wdata = dma_wdata;
                m_width = dma_width;
                m_read  = dma_req & ~dma_we;
                m_write = dma_req & dma_we;
                dma_ack = dma_req & m_ok;
                if (!dma_req) begin
                    state_nxt = IDLE;
                end else if (m_ok) begin
                    state_nxt = IDLE;
                    // Count DMA wins only while the CPU is actually waiting
                    if (cpu_req && (run_cnt != RUN_SAT)) begin
                        run_cnt_nxt = run_cnt + RUN_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter with a transaction-level
// reference model checked against the DUT on every falling edge.
module tb_mem_arbiter;

    localparam int unsigned DMA_RUN_MAX = 8;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_width;
    logic        cpu_we;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [1:0]  dma_width;
    logic        dma_we;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_width;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_rdata;
    logic        m_ok;
    logic [1:0]  grant;

    mem_arbiter #(.DMA_RUN_MAX(DMA_RUN_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_width (cpu_width),
        .cpu_we    (cpu_we),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_width (dma_width),
        .dma_we    (dma_we),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_width   (m_width),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_rdata   (m_rdata),
        .m_ok      (m_ok),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;
    bit drop_cpu = 1'b1;
    bit drop_dma = 1'b1;
    int ack_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port (0 none, 1 CPU, 2 DMA) and how many
    // DMA wins in a row the CPU has had to sit through.
    int owner = 0;
    int run   = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            owner = 0;
            run   = 0;
        end else if (owner == 0) begin
            if (dma_req && cpu_req && run >= int'(DMA_RUN_MAX)) owner = 1;
            else if (dma_req) owner = 2;
            else if (cpu_req) owner = 1;
            if (!cpu_req) run = 0;
        end else begin
            if ((owner == 1) ? !cpu_req : !dma_req) begin
                owner = 0;
            end else if (m_ok) begin
                if (owner == 1) run = 0;
                else if (cpu_req) run = (run < 255) ? run + 1 : 255;
                owner = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (checking) begin
            logic        req, we;
            logic [31:0] addr, wdata;
            logic [1:0]  width;
            req = 1'b0; we = 1'b0; addr = '0; wdata = '0; width = '0;
            if (owner == 1) begin
                req = cpu_req; we = cpu_we; addr = cpu_addr; wdata = cpu_wdata; width = cpu_width;
            end else if (owner == 2) begin
                req = dma_req; we = dma_we; addr = dma_addr; wdata = dma_wdata; width = dma_width;
            end
            chk("mon_grant",   32'(grant),   32'(owner));
            chk("mon_m_addr",  m_addr,       addr);
            chk("mon_m_wdata", m_wdata,      wdata);
            chk("mon_m_width", 32'(m_width), 32'(width));
            chk("mon_m_read",  32'(m_read),  32'(req & ~we));
            chk("mon_m_write", 32'(m_write), 32'(req & we));
            chk("mon_cpu_ack", 32'(cpu_ack), 32'(owner == 1 && cpu_req && m_ok));
            chk("mon_dma_ack", 32'(dma_ack), 32'(owner == 2 && dma_req && m_ok));
            chk("mon_run_cnt", 32'(dut.run_cnt), 32'(run));
            if (owner == 1 && cpu_req && m_ok) chk("mon_cpu_rdata", cpu_rdata, m_rdata);
            if (owner == 2 && dma_req && m_ok) chk("mon_dma_rdata", dma_rdata, m_rdata);
            if (cpu_ack) ack_log.push_back(1);
            if (dma_ack) ack_log.push_back(2);
        end
    end

    // Advance one cycle; requesters release their request after an ack
    task automatic step();
        logic a, d;
        @(negedge clk);
        a = cpu_ack;
        d = dma_ack;
        #1;
        if (a && drop_cpu) cpu_req = 1'b0;
        if (d && drop_dma) dma_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        m_ok    = 1'b1;
        step();
        step();
        ack_log.delete();
    endtask

    int n_dma_first;

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_addr = '0; cpu_wdata = '0; cpu_width = '0; cpu_we = 0;
        dma_req = 0; dma_addr = '0; dma_wdata = '0; dma_width = '0; dma_we = 0;
        m_rdata = '0; m_ok = 1'b1;
        step();
        step();
        checking = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("reset_grant",   32'(grant),   32'd0);
        chk("reset_m_read",  32'(m_read),  32'd0);
        chk("reset_m_write", 32'(m_write), 32'd0);
        chk("reset_m_addr",  m_addr,       32'd0);
        chk("reset_acks",    32'({cpu_ack, dma_ack}), 32'd0);

        // 1: single CPU word read
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0300_0010; cpu_width = 2'd2;
        m_ok = 1; m_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_grant_c0", 32'(grant), 32'd0);
        step();
        chk("t1_grant_c1", 32'(grant),   32'h1);
        chk("t1_m_read",   32'(m_read),  32'd1);
        chk("t1_m_addr",   m_addr,       32'h0300_0010);
        chk("t1_cpu_ack",  32'(cpu_ack), 32'd1);
        chk("t1_cpu_rdata", cpu_rdata,   32'hDEAD_BEEF);
        step();
        chk("t1_grant_c2", 32'(grant), 32'd0);
        chk("t1_acks", 32'(ack_log.size()), 32'd1);
        quiesce();

        // 2: DMA byte write stalled three cycles
        dma_req = 1; dma_we = 1; dma_addr = 32'h0200_0003; dma_wdata = 32'h0000_00AB; dma_width = 2'd0;
        m_ok = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 4) m_ok = 1;
            #1;
            chk("t2_m_write", 32'(m_write), 32'd1);
            chk("t2_m_width", 32'(m_width), 32'd0);
            chk("t2_m_wdata", m_wdata,      32'h0000_00AB);
            chk("t2_m_addr",  m_addr,       32'h0200_0003);
            chk("t2_dma_ack", 32'(dma_ack), 32'(k == 4));
        end
        step();
        chk("t2_grant_end", 32'(grant), 32'd0);
        chk("t2_acks", 32'(ack_log.size()), 32'd1);
        quiesce();

        // 3: simultaneous requests, DMA first then CPU two cycles later
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_1000; cpu_width = 2'd2;
        dma_req = 1; dma_we = 1; dma_addr = 32'h0000_2000; dma_width = 2'd1; dma_wdata = 32'h1234_5678;
        m_ok = 1; m_rdata = 32'hCAFE_F00D;
        step(); chk("t3_grant_c1", 32'(grant), 32'h2);
        step(); chk("t3_grant_c2", 32'(grant), 32'h0);
        step(); chk("t3_grant_c3", 32'(grant), 32'h1);
        step(); chk("t3_grant_c4", 32'(grant), 32'h0);
        chk("t3_ack_count", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) begin
            chk("t3_first_ack",  32'(ack_log[0]), 32'd2);
            chk("t3_second_ack", 32'(ack_log[1]), 32'd1);
        end
        quiesce();

        // 4: starvation guard with DMA continuously requesting
        drop_dma = 1'b0;
        cpu_req = 1; dma_req = 1; m_ok = 1;
        for (int k = 0; k < 22; k++) step();
        chk("t4_ack_count_ge10", 32'(ack_log.size() >= 10), 32'd1);
        n_dma_first = 0;
        while (n_dma_first < ack_log.size() && ack_log[n_dma_first] == 2) n_dma_first++;
        chk("t4_dma_run", 32'(n_dma_first), 32'd8);
        if (ack_log.size() >= 10) begin
            chk("t4_cpu_slot",  32'(ack_log[8]), 32'd1);
            chk("t4_dma_again", 32'(ack_log[9]), 32'd2);
        end
        chk("t4_run_cnt_cleared", 32'(dut.run_cnt), 32'd0);
        drop_dma = 1'b1;
        quiesce();

        // 5: reset during a stalled DMA read, request held across reset
        dma_req = 1; dma_we = 0; dma_addr = 32'h0400_0000; dma_width = 2'd2;
        m_ok = 0; m_rdata = 32'h5555_AAAA;
        step(); chk("t5_grant_dma", 32'(grant), 32'h2);
        step();
        rst_n = 0;
        step();
        chk("t5_grant_rst",  32'(grant),   32'd0);
        chk("t5_m_read_rst", 32'(m_read),  32'd0);
        chk("t5_m_write_rst", 32'(m_write), 32'd0);
        chk("t5_no_ack",     32'(ack_log.size()), 32'd0);
        rst_n = 1;
        step();
        chk("t5_regrant", 32'(grant), 32'h2);
        m_ok = 1;
        step();
        chk("t5_ack_after", 32'(ack_log.size()), 32'd1);
        quiesce();

        // 6: CPU abandons a stalled read
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0040; cpu_width = 2'd1;
        m_ok = 0;
        step(); chk("t6_m_read", 32'(m_read), 32'd1);
        step();
        cpu_req = 0;
        #1;
        chk("t6_m_read_drop", 32'(m_read), 32'd0);
        chk("t6_grant_hold",  32'(grant),  32'h1);
        step();
        chk("t6_grant_idle", 32'(grant), 32'd0);
        chk("t6_no_ack", 32'(ack_log.size()), 32'd0);
        quiesce();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
